// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue_pkg
// Brief    : Shared widths, NOP encoding and fetch-entry type for the
//            fetch->decode instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    // Value presented on the instruction bus whenever no real instruction is held
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One buffered fetch result: the instruction word and the PC it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential PC of the following instruction, wrapping at 2^32
    function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_storage.sv
`default_nettype none
// ============================================================================
// Module   : iq_storage
// Brief    : DEPTH-entry register array for the fetch queue. Synchronous
//            write at the write pointer, asynchronous read at the read pointer.
// Revision : 1.0 - initial release
// ============================================================================
module iq_storage
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
)(
    input  logic               CLK,
    input  logic               Wr_En_i,
    input  logic [PTR_W-1:0]   Wr_Ptr_i,
    input  fetch_entry_t       Wr_Data_i,
    input  logic [PTR_W-1:0]   Rd_Ptr_i,
    output fetch_entry_t       Rd_Data_o
);

    // Contents are only meaningful below the occupancy count, so no reset is needed
    fetch_entry_t mem_q [DEPTH];

    // Capture the incoming entry into the slot addressed by the write pointer
    always_ff @(posedge CLK) begin
        if (Wr_En_i) begin
            mem_q[Wr_Ptr_i] <= Wr_Data_i;
        end
    end

    assign Rd_Data_o = mem_q[Rd_Ptr_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Fetch->decode instruction queue. Buffers {instr, PC} pairs from
//            IF and presents one registered entry per cycle to ID, with
//            freeze hold, empty-queue bypass and flush on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
)(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INSTR_W-1:0]  Instr_IN,
    input  logic [ADDR_W-1:0]   Instr_PC_IN,
    input  logic                Instr_Valid_IN,
    output logic                Full_OUT,
    output logic [PTR_W:0]      Count_OUT,
    output logic                Overflow_OUT,
    input  logic                Flush_IN,
    input  logic                Request_Instr1,
    input  logic                WANT_FREEZE,
    output logic [INSTR_W-1:0]  Instr1_OUT,
    output logic                Instr1_Valid_OUT,
    output logic [ADDR_W-1:0]   Instr_PC_OUT,
    output logic [ADDR_W-1:0]   Instr_PC_Plus4_OUT
);

    localparam int CNT_W = PTR_W + 1;

    // Queue bookkeeping
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               overflow_q, overflow_d;

    // Output register presented to ID
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [ADDR_W-1:0]  pc4_q,   pc4_d;

    // Control decode
    logic               w_pop_en;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_store_wr;
    logic               w_store_rd;
    fetch_entry_t       w_in_entry;
    fetch_entry_t       w_head;

    assign w_pop_en   = Request_Instr1 && !WANT_FREEZE;
    assign w_full     = (count_q == CNT_W'(DEPTH));
    assign w_empty    = (count_q == '0);
    assign w_push_ok  = Instr_Valid_IN && (!w_full || w_pop_en) && !Flush_IN;
    // A push into an empty queue that is being popped goes straight to the
    // output register and never occupies a storage slot
    assign w_store_wr = w_push_ok && !(w_pop_en && w_empty);
    assign w_store_rd = w_pop_en && !w_empty && !Flush_IN;

    assign w_in_entry.instr = Instr_IN;
    assign w_in_entry.pc    = Instr_PC_IN;

    iq_storage #(
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_storage (
        .CLK        (CLK),
        .Wr_En_i    (w_store_wr),
        .Wr_Ptr_i   (wr_ptr_q),
        .Wr_Data_i  (w_in_entry),
        .Rd_Ptr_i   (rd_ptr_q),
        .Rd_Data_o  (w_head)
    );

    // Next-state: flush beats freeze, freeze beats pop, pop prefers stored head over bypass
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;

        if (Flush_IN) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
        end else begin
            if (!w_pop_en) begin
                // Freeze: hold the presented entry; a push into a full queue is lost
                if (Instr_Valid_IN && w_full) begin
                    overflow_d = 1'b1;
                end
            end else if (!w_empty) begin
                valid_d  = 1'b1;
                instr_d  = w_head.instr;
                pc_d     = w_head.pc;
                pc4_d    = pc_plus4(w_head.pc);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else if (w_push_ok) begin
                valid_d  = 1'b1;
                instr_d  = Instr_IN;
                pc_d     = Instr_PC_IN;
                pc4_d    = pc_plus4(Instr_PC_IN);
            end else begin
                // Nothing to hand over: drop valid, keep the last PC for debug visibility
                valid_d  = 1'b0;
                instr_d  = NOP_INSTR;
            end

            if (w_store_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_store_wr) - CNT_W'(w_store_rd);
        end
    end

    // State and output registers, cleared immediately when RESET falls
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc4_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
        end
    end

    assign Full_OUT           = w_full;
    assign Count_OUT          = count_q;
    assign Overflow_OUT       = overflow_q;
    assign Instr1_Valid_OUT   = valid_q;
    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = pc_q;
    assign Instr_PC_Plus4_OUT = pc4_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Self-checking bench for instr_fetch_queue: queue-based reference
//            model compared every cycle, plus directed literal scenarios and
//            biased random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] Instr_IN = '0;
    logic [31:0] Instr_PC_IN = '0;
    logic        Instr_Valid_IN = 1'b0;
    logic        Flush_IN = 1'b0;
    logic        Request_Instr1 = 1'b0;
    logic        WANT_FREEZE = 1'b0;
    logic        Full_OUT;
    logic [3:0]  Count_OUT;
    logic        Overflow_OUT;
    logic [31:0] Instr1_OUT;
    logic        Instr1_Valid_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;

    instr_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Instr_IN           (Instr_IN),
        .Instr_PC_IN        (Instr_PC_IN),
        .Instr_Valid_IN     (Instr_Valid_IN),
        .Full_OUT           (Full_OUT),
        .Count_OUT          (Count_OUT),
        .Overflow_OUT       (Overflow_OUT),
        .Flush_IN           (Flush_IN),
        .Request_Instr1     (Request_Instr1),
        .WANT_FREEZE        (WANT_FREEZE),
        .Instr1_OUT         (Instr1_OUT),
        .Instr1_Valid_OUT   (Instr1_Valid_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain queue of {instr, pc} plus the ID-side view
    // ------------------------------------------------------------------
    logic [63:0] m_q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pc4   = '0;
    logic        m_ovf   = 1'b0;
    bit          m_pop;
    logic [63:0] m_e;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_q.delete();
            m_valid = 1'b0;
            m_instr = '0;
            m_pc    = '0;
            m_pc4   = '0;
            m_ovf   = 1'b0;
        end else begin
            m_pop = Request_Instr1 && !WANT_FREEZE;
            if (Flush_IN) begin
                m_q.delete();
                m_valid = 1'b0;
                m_instr = '0;
            end else if (!m_pop) begin
                if (Instr_Valid_IN) begin
                    if (m_q.size() < DEPTH) m_q.push_back({Instr_IN, Instr_PC_IN});
                    else                    m_ovf = 1'b1;
                end
            end else if (m_q.size() > 0) begin
                m_e     = m_q.pop_front();
                m_valid = 1'b1;
                m_instr = m_e[63:32];
                m_pc    = m_e[31:0];
                m_pc4   = m_e[31:0] + 32'd4;
                if (Instr_Valid_IN) m_q.push_back({Instr_IN, Instr_PC_IN});
            end else if (Instr_Valid_IN) begin
                m_valid = 1'b1;
                m_instr = Instr_IN;
                m_pc    = Instr_PC_IN;
                m_pc4   = Instr_PC_IN + 32'd4;
            end else begin
                m_valid = 1'b0;
                m_instr = '0;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_valid", {31'd0, Instr1_Valid_OUT}, {31'd0, m_valid});
            chk("m_instr", Instr1_OUT, m_instr);
            chk("m_pc",    Instr_PC_OUT, m_pc);
            chk("m_pc4",   Instr_PC_Plus4_OUT, m_pc4);
            chk("m_count", {28'd0, Count_OUT}, 32'(m_q.size()));
            chk("m_full",  {31'd0, Full_OUT}, {31'd0, (m_q.size() == DEPTH)});
            chk("m_ovf",   {31'd0, Overflow_OUT}, {31'd0, m_ovf});
        end
    end

    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit req, input bit frz, input bit fl);
        Instr_Valid_IN = v;
        Instr_IN       = ins;
        Instr_PC_IN    = pc;
        Request_Instr1 = req;
        WANT_FREEZE    = frz;
        Flush_IN       = fl;
        @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk({tag, "_instr"}, Instr1_OUT, 32'd0);
        chk({tag, "_pc"},    Instr_PC_OUT, 32'd0);
        chk({tag, "_pc4"},   Instr_PC_Plus4_OUT, 32'd0);
        chk({tag, "_count"}, {28'd0, Count_OUT}, 32'd0);
        chk({tag, "_full"},  {31'd0, Full_OUT}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, Overflow_OUT}, 32'd0);
    endtask

    int          req_pct;
    logic [31:0] r_pc;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RESET  = 1'b1;
        cmp_en = 1'b1;

        // Three back-to-back pushes into an empty queue, bypassed with one-edge latency
        cyc(1, 32'h11, 32'h0040_0000, 1, 0, 0);
        chk("byp0_valid", {31'd0, Instr1_Valid_OUT}, 32'd1);
        chk("byp0_pc4",   Instr_PC_Plus4_OUT, 32'h0040_0004);
        chk("byp0_instr", Instr1_OUT, 32'h11);
        cyc(1, 32'h22, 32'h0040_0004, 1, 0, 0);
        chk("byp1_pc4",   Instr_PC_Plus4_OUT, 32'h0040_0008);
        cyc(1, 32'h33, 32'h0040_0008, 1, 0, 0);
        chk("byp2_pc4",   Instr_PC_Plus4_OUT, 32'h0040_000C);
        chk("byp2_valid", {31'd0, Instr1_Valid_OUT}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0);
        chk("byp_end_valid", {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk("byp_end_instr", Instr1_OUT, 32'd0);

        // Fill with ID stalled, then one more push that must be dropped
        for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 32'h1000 + 4 * i, 0, 0, 0);
        chk("fill_count", {28'd0, Count_OUT}, 32'd8);
        chk("fill_full",  {31'd0, Full_OUT}, 32'd1);
        chk("fill_ovf",   {31'd0, Overflow_OUT}, 32'd0);
        cyc(1, 32'hBAD, 32'h2000, 0, 0, 0);
        chk("ovf_full",  {31'd0, Full_OUT}, 32'd1);
        chk("ovf_set",   {31'd0, Overflow_OUT}, 32'd1);
        chk("ovf_count", {28'd0, Count_OUT}, 32'd8);

        // Drain two, freeze for four cycles, then resume with the next entry
        cyc(0, 32'h0, 32'h0, 1, 0, 0);
        chk("drain0_pc", Instr_PC_OUT, 32'h1000);
        cyc(0, 32'h0, 32'h0, 1, 0, 0);
        chk("drain1_pc", Instr_PC_OUT, 32'h1004);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 32'h0, 1, 1, 0);
            chk("frz_pc",    Instr_PC_OUT, 32'h1004);
            chk("frz_instr", Instr1_OUT, 32'hA1);
        end
        cyc(0, 32'h0, 32'h0, 1, 0, 0);
        chk("resume_pc",    Instr_PC_OUT, 32'h1008);
        chk("resume_instr", Instr1_OUT, 32'hA2);
        chk("resume_count", {28'd0, Count_OUT}, 32'd5);

        // Flush at count 5 with a concurrent push
        cyc(1, 32'h77, 32'h3000, 1, 0, 1);
        chk("flush_count", {28'd0, Count_OUT}, 32'd0);
        chk("flush_valid", {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk("flush_instr", Instr1_OUT, 32'd0);
        chk("flush_ovf",   {31'd0, Overflow_OUT}, 32'd1);

        // PC+4 wraps at the top of the address space
        cyc(1, 32'h0000_000C, 32'hFFFF_FFFC, 1, 0, 0);
        chk("wrap_valid", {31'd0, Instr1_Valid_OUT}, 32'd1);
        chk("wrap_pc4",   Instr_PC_Plus4_OUT, 32'h0000_0000);
        chk("wrap_instr", Instr1_OUT, 32'h0000_000C);

        // Asynchronous reset with six entries buffered
        for (int i = 0; i < 6; i++) cyc(1, 32'h50 + i, 32'h5000 + 4 * i, 0, 0, 0);
        chk("pre_rst_count", {28'd0, Count_OUT}, 32'd6);
        #2 RESET = 1'b0;
        #1 chk_all_zero("async_rst");
        Instr_Valid_IN = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        cyc(1, 32'h99, 32'h6000, 1, 0, 0);
        chk("post_rst_pc",    Instr_PC_OUT, 32'h6000);
        chk("post_rst_valid", {31'd0, Instr1_Valid_OUT}, 32'd1);
        cyc(1, 32'h9A, 32'h6004, 0, 0, 0);
        chk("post_rst_count", {28'd0, Count_OUT}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0);
        chk("post_rst_pc2",   Instr_PC_OUT, 32'h6004);

        // Random traffic in three phases of differing ID readiness
        for (int ph = 0; ph < 3; ph++) begin
            req_pct = 30 + 30 * ph;
            for (int n = 0; n < 700; n++) begin
                r_pc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 19) == 0) r_pc = 32'hFFFF_FFFC;
                cyc($urandom_range(0, 99) < 70, $urandom, r_pc,
                    $urandom_range(0, 99) < req_pct,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 3);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
